// File: rtl/wb_arbiter_wrr_if.sv
// Bundle of arbiter request/grant signals between the Wishbone masters
// and the weighted round-robin arbiter.
//   request       : per-master CYC
//   acknowledge   : per-master ACK/ERR
//   weight        : packed per-port burst quotas, field i = [i*WEIGHT_W +: WEIGHT_W]
//   grant         : one-hot grant (also drives the interconnect mux)
//   grant_valid   : a grant is active
//   grant_encoded : index of the granted port
//   timeout       : one-cycle pulse when a grant is revoked for lack of ACK
// The master modport is the requesting side, the slave modport is the arbiter.
interface wb_arbiter_wrr_if #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4
);
  localparam int PW = $clog2(PORTS);

  logic [PORTS-1:0]          request;
  logic [PORTS-1:0]          acknowledge;
  logic [PORTS*WEIGHT_W-1:0] weight;
  logic [PORTS-1:0]          grant;
  logic                      grant_valid;
  logic [PW-1:0]             grant_encoded;
  logic                      timeout;

  modport master (
    output request, acknowledge, weight,
    input  grant, grant_valid, grant_encoded, timeout
  );

  modport slave (
    input  request, acknowledge, weight,
    output grant, grant_valid, grant_encoded, timeout
  );
endinterface

// File: rtl/wb_arbiter_wrr.sv
// Weighted round-robin Wishbone arbiter. Each grant is held for a burst
// quota (weight, 0 counts as 1) of acknowledged transfers, released early
// when the master drops CYC, or revoked after TIMEOUT cycles without ACK.
// On release the next winner is granted directly, with no idle cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_arbiter_wrr_if.slave (request/acknowledge/weight in,
//              grant/grant_valid/grant_encoded/timeout out, all registered)
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// GRANT | grant_encoded port owns the bus until a release condition
module wb_arbiter_wrr #(
  parameter int PORTS                = 4,
  parameter int WEIGHT_W             = 4,
  parameter bit ARB_TYPE_ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT              = 0,
  parameter int CNT_W                = 16
) (
  input  logic           clk,
  input  logic           rst,
  wb_arbiter_wrr_if.slave bus
);
  localparam int PW = $clog2(PORTS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [PORTS-1:0]    grant_q, grant_d;
  logic                grant_valid_q, grant_valid_d;
  logic [PW-1:0]       grant_encoded_q, grant_encoded_d;
  logic                timeout_q, timeout_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [PW-1:0]       ptr_q, ptr_d;

  logic [WEIGHT_W-1:0] weight_arr [PORTS];

  // Returns {found, index}. Round robin searches upward from ptr+1 and wraps.
  function automatic logic [PW:0] pick(input logic [PORTS-1:0] req,
                                       input logic [PW-1:0]    ptr);
    logic          found;
    logic [PW-1:0] win;
    int            idx;
    found = 1'b0;
    win   = '0;
    if (ARB_TYPE_ROUND_ROBIN) begin
      for (int i = 1; i <= PORTS; i++) begin
        idx = (int'(ptr) + i) % PORTS;
        if (!found && req[PW'(idx)]) begin
          found = 1'b1;
          win   = PW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (!found && req[PW'(i)]) begin
          found = 1'b1;
          win   = PW'(i);
        end
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      weight_arr[i] = bus.weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  logic [PW:0]         sel;
  logic                sel_found;
  logic [PW-1:0]       sel_win;
  logic [WEIGHT_W-1:0] sel_weight;
  logic                ack_g, rel_a, rel_b, rel_c, do_pick;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    grant_valid_d   = grant_valid_q;
    grant_encoded_d = grant_encoded_q;
    timeout_d       = 1'b0;
    credit_d        = credit_q;
    timer_d         = timer_q;
    ptr_d           = ptr_q;
    do_pick         = 1'b0;

    // While granted the pointer equals the holder, so one pick serves both
    // the idle arbitration and the handover on release.
    sel        = pick(bus.request, (state_q == GRANT) ? grant_encoded_q : ptr_q);
    sel_found  = sel[PW];
    sel_win    = sel[PW-1:0];
    sel_weight = weight_arr[sel_win];

    ack_g = bus.acknowledge[grant_encoded_q];
    rel_a = ack_g && (credit_q == WEIGHT_W'(1));
    rel_b = !bus.request[grant_encoded_q];
    rel_c = (TIMEOUT != 0) && (timer_q == CNT_W'(TIMEOUT - 1)) && !ack_g;

    case (state_q)
      IDLE: do_pick = |bus.request;
      GRANT: begin
        if (rel_a || rel_b || rel_c) begin
          do_pick   = 1'b1;
          // Ordinary releases win over a coincident timeout.
          timeout_d = rel_c && !rel_a && !rel_b;
        end else if (ack_g) begin
          credit_d = credit_q - WEIGHT_W'(1);
          timer_d  = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_pick) begin
      timer_d = '0;
      if (sel_found) begin
        state_d         = GRANT;
        grant_d         = PORTS'(1) << sel_win;
        grant_valid_d   = 1'b1;
        grant_encoded_d = sel_win;
        credit_d        = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;
        if (ARB_TYPE_ROUND_ROBIN) ptr_d = sel_win;
      end else begin
        state_d         = IDLE;
        grant_d         = '0;
        grant_valid_d   = 1'b0;
        grant_encoded_d = '0;
        credit_d        = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      grant_valid_q   <= 1'b0;
      grant_encoded_q <= '0;
      timeout_q       <= 1'b0;
      credit_q        <= '0;
      timer_q         <= '0;
      ptr_q           <= PW'(PORTS - 1);
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      grant_valid_q   <= grant_valid_d;
      grant_encoded_q <= grant_encoded_d;
      timeout_q       <= timeout_d;
      credit_q        <= credit_d;
      timer_q         <= timer_d;
      ptr_q           <= ptr_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_encoded = grant_encoded_q;
  assign bus.timeout       = timeout_q;
endmodule
